// File: rtl/mfp_ahb_uart_tx_if.sv
// AHB-lite signal bundle for the UART transmitter slave slot.
interface mfp_ahb_uart_tx_if;
  logic [1:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;

  modport master (output HADDR, HTRANS, HWDATA, HWRITE, HSEL, input HRDATA);
  modport slave  (input HADDR, HTRANS, HWDATA, HWRITE, HSEL, output HRDATA);
endinterface

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-lite serial console transmitter: 8-entry byte FIFO feeding an 8N1 shifter.
// Zero wait states; HRDATA is registered one cycle after the address phase.
module mfp_ahb_uart_tx #(
  parameter int CLKS_PER_BIT = 109,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             HCLK,
  input  logic             rstn,
  mfp_ahb_uart_tx_if.slave bus,
  output logic             TXD,
  output logic             IRQ
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic             addr_phase_p0;
  logic             wr_p1;
  logic [1:0]       addr_p1;
  logic [31:0]      hrdata, rd_word;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [LVL_W-1:0] level;
  logic             full, empty, busy;
  logic             overflow, tx_en, irq_en;
  logic             push, push_ok, pop;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             tick;
  logic             unused_hwdata;

  function automatic logic [31:0] status_word(input logic [LVL_W-1:0] lvl,
                                              input logic ovf, input logic bsy,
                                              input logic emp, input logic ful);
    logic [7:0] lvl8;
    lvl8 = 8'(lvl);
    return {24'd0, lvl8[3:0], ovf, bsy, emp, ful};
  endfunction

  assign full          = (level == LVL_FULL);
  assign empty         = (level == '0);
  assign busy          = (state != IDLE);
  assign IRQ           = irq_en && empty && !busy;
  assign bus.HRDATA    = hrdata;
  assign unused_hwdata = ^bus.HWDATA[31:8];

  // Read mux samples current state, so a read overlapping a write data phase sees pre-write values
  always_comb begin
    rd_word = 32'd0;
    case (bus.HADDR)
      2'd1:    rd_word = status_word(level, overflow, busy, empty, full);
      2'd2:    rd_word = {30'd0, irq_en, tx_en};
      default: rd_word = 32'd0;
    endcase
  end

  // ---- p0 -> p1: address phase capture ----
  assign addr_phase_p0 = bus.HSEL && (bus.HTRANS != 2'b00);

  always_ff @(posedge HCLK) begin
    addr_p1 <= bus.HADDR;
    if (!rstn) begin
      wr_p1  <= 1'b0;
      hrdata <= 32'd0;
    end else begin
      wr_p1 <= addr_phase_p0 && bus.HWRITE;
      if (addr_phase_p0 && !bus.HWRITE)
        hrdata <= rd_word;
    end
  end

  // ---- p1: write data phase ----
  assign push    = wr_p1 && (addr_p1 == 2'd0);
  assign push_ok = push && !full;

  always_ff @(posedge HCLK) begin
    if (!rstn) begin
      overflow <= 1'b0;
      tx_en    <= 1'b1;
      irq_en   <= 1'b0;
    end else if (wr_p1) begin
      case (addr_p1)
        2'd0:    if (full) overflow <= 1'b1;
        2'd1:    if (bus.HWDATA[3]) overflow <= 1'b0;
        2'd2:    begin
                   tx_en  <= bus.HWDATA[0];
                   irq_en <= bus.HWDATA[1];
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok)
      mem[wptr] <= bus.HWDATA[7:0];
  end

  // Full is judged before the edge, so a simultaneous pop never rescues a push into a full FIFO
  always_ff @(posedge HCLK) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // ---- TX serializer ----
  assign tick = (cnt == BIT_LAST);

  always_ff @(posedge HCLK) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_en && !empty) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    TXD = 1'b1;
    pop = 1'b0;
    case (state)
      IDLE:    pop = tx_en && !empty;
      START:   TXD = 1'b0;
      DATA:    TXD = shift[0];
      default: TXD = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!rstn || state == IDLE) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else if (tick) begin
      cnt <= '0;
      if (state == DATA) bit_idx <= bit_idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (pop)
      shift <= mem[rptr];
    else if (state == DATA && tick)
      shift <= {1'b0, shift[7:1]};
  end
endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Directed bench for mfp_ahb_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_mfp_ahb_uart_tx;
  localparam int CPB = 4;

  logic HCLK = 1'b0;
  logic rstn = 1'b0;
  logic TXD, IRQ;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  mfp_ahb_uart_tx_if bus();

  mfp_ahb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .HCLK (HCLK),
    .rstn (rstn),
    .bus  (bus),
    .TXD  (TXD),
    .IRQ  (IRQ)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 2'd0;
  endtask

  // Called at a negedge; returns at the negedge after the data-phase edge.
  task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a;
    @(negedge HCLK);
    bus_idle();
    bus.HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [1:0] a, output logic [31:0] d);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a;
    @(negedge HCLK);
    bus_idle();
    d = bus.HRDATA;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge HCLK);
    rstn = 1'b1;
  endtask

  // Waits (bounded) for a start bit, then samples the whole 10-bit frame.
  task automatic capture_frame(output logic [7:0] b, output bit ok, output int t0);
    logic [9:0] frame;
    frame = '0;
    ok = 1'b0;
    b  = 8'h00;
    t0 = 0;
    for (int i = 0; i < 200 && TXD !== 1'b0; i++) @(negedge HCLK);
    if (TXD !== 1'b0) return;
    ok = 1'b1;
    t0 = cycle;
    for (int s = 0; s < 10*CPB; s++) begin
      if (s != 0) @(negedge HCLK);
      if (s % CPB == 0) frame[s/CPB] = TXD;
      else if (TXD !== frame[s/CPB]) ok = 1'b0;
    end
    if (frame[0] !== 1'b0 || frame[9] !== 1'b1) ok = 1'b0;
    b = frame[8:1];
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus_idle();
    bus.HWDATA = 32'd0;
    repeat (3) @(negedge HCLK);
    checks++; if (bus.HRDATA !== 32'd0) begin errors++; $display("FAIL reset_hrdata: got %h expected 00000000", bus.HRDATA); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", TXD); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
    rstn = 1'b1;
    @(negedge HCLK);
    ahb_read(2'd1, r);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL reset_status: got %h expected 00000002", r); end
    ahb_read(2'd2, r);
    checks++; if (r !== 32'h01) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000001", r); end
    ahb_read(2'd3, r);
    checks++; if (r !== 32'h00) begin errors++; $display("FAIL reset_addr3: got %h expected 00000000", r); end
    ahb_read(2'd0, r);
    checks++; if (r !== 32'h00) begin errors++; $display("FAIL reset_data_read: got %h expected 00000000", r); end
  endtask

  task automatic test_single_byte();
    logic [7:0]  b;
    logic [31:0] r;
    bit          ok;
    int          t0;
    ahb_write(2'd0, 32'h55);
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL single_pre_start: got %b expected 1", TXD); end
    @(negedge HCLK);
    checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL single_start_latency: got %b expected 0", TXD); end
    capture_frame(b, ok, t0);
    checks++; if (!ok || b !== 8'h55) begin errors++; $display("FAIL single_frame: got byte %h ok=%0d expected 55 ok=1", b, ok); end
    @(negedge HCLK);
    ahb_read(2'd1, r);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL single_status_after: got %h expected 00000002", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    ahb_write(2'd2, 32'h0);
    for (int i = 0; i < 9; i++) ahb_write(2'd0, i);
    ahb_read(2'd1, r);
    checks++; if (r !== 32'h89) begin errors++; $display("FAIL overflow_status: got %h expected 00000089", r); end
    ahb_write(2'd1, 32'h08);
    ahb_read(2'd1, r);
    checks++; if (r !== 32'h81) begin errors++; $display("FAIL overflow_clear: got %h expected 00000081", r); end
  endtask

  task automatic test_drain();
    logic [7:0]  b;
    logic [31:0] r;
    bit          ok;
    int          t0, prev;
    prev = 0;
    ahb_write(2'd2, 32'h3);
    for (int k = 0; k < 8; k++) begin
      capture_frame(b, ok, t0);
      checks++; if (!ok || b !== 8'(k)) begin errors++; $display("FAIL drain_frame%0d: got byte %h ok=%0d expected %h ok=1", k, b, ok, 8'(k)); end
      if (k > 0) begin
        checks++; if (t0 - prev !== 41) begin errors++; $display("FAIL drain_period%0d: got %0d expected 41", k, t0 - prev); end
      end
      prev = t0;
    end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL drain_irq_in_stop: got %b expected 0", IRQ); end
    @(negedge HCLK);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL drain_irq_done: got %b expected 1", IRQ); end
    ahb_read(2'd1, r);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL drain_status: got %h expected 00000002", r); end
    ahb_write(2'd2, 32'h0);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL drain_irq_masked: got %b expected 0", IRQ); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 2'd0;
    @(negedge HCLK);
    bus.HWDATA = 32'h77; bus.HWRITE = 1'b0; bus.HADDR = 2'd1;
    @(negedge HCLK);
    r1 = bus.HRDATA;
    @(negedge HCLK);
    bus_idle();
    r2 = bus.HRDATA;
    checks++; if (r1 !== 32'h02) begin errors++; $display("FAIL b2b_read_pre_write: got %h expected 00000002", r1); end
    checks++; if (r2 !== 32'h10) begin errors++; $display("FAIL b2b_read_post_write: got %h expected 00000010", r2); end
  endtask

  task automatic test_disable_mid_frame();
    logic [7:0]  b;
    logic [31:0] r;
    bit          ok, idle_ok;
    int          t0;
    do_reset();
    ahb_write(2'd0, 32'hA5);
    fork
      capture_frame(b, ok, t0);
      begin
        ahb_write(2'd0, 32'h3C);
        repeat (14) @(negedge HCLK);
        ahb_write(2'd2, 32'h0);
      end
    join
    checks++; if (!ok || b !== 8'hA5) begin errors++; $display("FAIL disable_frame: got byte %h ok=%0d expected a5 ok=1", b, ok); end
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge HCLK);
      if (TXD !== 1'b1) idle_ok = 1'b0;
    end
    checks++; if (!idle_ok) begin errors++; $display("FAIL disable_txd_idle: got activity expected constant 1"); end
    ahb_read(2'd1, r);
    checks++; if (r !== 32'h10) begin errors++; $display("FAIL disable_status: got %h expected 00000010", r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    bit          idle_ok;
    ahb_write(2'd0, 32'h11);
    ahb_write(2'd0, 32'h22);
    ahb_write(2'd0, 32'h33);
    ahb_write(2'd2, 32'h3);
    for (int i = 0; i < 200 && TXD !== 1'b0; i++) @(negedge HCLK);
    checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL midreset_start_seen: got %b expected 0", TXD); end
    repeat (5) @(negedge HCLK);
    checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL midreset_bit0: got %b expected 0", TXD); end
    rstn = 1'b0;
    @(negedge HCLK);
    rstn = 1'b1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL midreset_txd: got %b expected 1", TXD); end
    checks++; if (bus.HRDATA !== 32'd0) begin errors++; $display("FAIL midreset_hrdata: got %h expected 00000000", bus.HRDATA); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", IRQ); end
    ahb_read(2'd1, r);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL midreset_status: got %h expected 00000002", r); end
    ahb_read(2'd2, r);
    checks++; if (r !== 32'h01) begin errors++; $display("FAIL midreset_ctrl: got %h expected 00000001", r); end
    idle_ok = 1'b1;
    repeat (50) begin
      @(negedge HCLK);
      if (TXD !== 1'b1) idle_ok = 1'b0;
    end
    checks++; if (!idle_ok) begin errors++; $display("FAIL midreset_flushed: got activity expected constant 1"); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_disable_mid_frame();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
